mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the MEM-stage data requester of the 5-stage MIPS pipeline.
- Sequences each access: grant, issue, a fixed latency wait, then data return.
- Generates per-stage stall signals that feed the pipeline register enables, so fetch and data-memory accesses never collide on the memory port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the MemEn cycle to the cycle MemRdata is valid (legal range 1..15)

Ports:
Clk  in  1  clock; all state updates on posedge
Rst_n  in  1  synchronous, active-low reset
IfReq  in  1  fetch request; held high until IfValid or IfAbort
IfAddr  in  ADDR_W  fetch address (PC)
IfAbort  in  1  cancel fetch (branch/jump flush)
IfRdata  out  DATA_W  fetched instruction, registered
IfValid  out  1  one-cycle fetch-done pulse
DmReq  in  1  data request; held high until DmValid
DmWe  in  1  1 = store, 0 = load
DmAddr  in  ADDR_W  data address (ALU result)
DmWdata  in  DATA_W  store data
DmRdata  out  DATA_W  load data, registered
DmValid  out  1  one-cycle data-done pulse
MemEn  out  1  memory access strobe
MemWe  out  1  memory write enable
MemAddr  out  ADDR_W  memory address
MemWdata  out  DATA_W  memory write data
MemRdata  in  DATA_W  memory read data
StallIF  out  1  freeze PC and IF/ID
StallMEM  out  1  freeze EX/MEM and upstream stages
Busy  out  1  state != IDLE

Behaviour:
- Clock and reset: Clk is the single clock. Rst_n is synchronous, active-low.
- Reset (sampled low at any time, including mid-transaction):
  - next state is IDLE; latency counter 0
  - MemEn, MemWe, IfValid, DmValid, Busy all 0
  - MemAddr, MemWdata, IfRdata, DmRdata all 0
  - the in-flight transaction is discarded; no Valid pulse is ever produced for it.
- States:
  - IDLE: no access outstanding.
  - ISSUE: MemEn=1 for exactly one cycle; MemAddr/MemWe/MemWdata registered from the granted requester.
  - WAIT: counter counts MEM_LAT cycles.
  - DONE: one cycle; Valid pulse. Counts as IDLE for grant decisions.
- Grant, evaluated in IDLE or DONE:
  - DmReq has priority over IfReq (older instruction).
  - The requester whose Valid is high in the current cycle is ignored; this gives alternation under continuous requests.
  - IfReq with IfAbort high in the same cycle is not granted.
  - Grant leads to ISSUE in the next cycle; no grant leads to IDLE.
- Store (DmWe=1): the write happens in the ISSUE cycle; ISSUE goes to DONE; DmRdata is unchanged. Store latency: req cycle 0, MemEn cycle 1, DmValid cycle 2.
- Load/fetch: ISSUE goes to WAIT. MemRdata is captured into IfRdata/DmRdata on the posedge ending cycle ISSUE+MEM_LAT, then DONE. Latency: req cycle 0, MemEn cycle 1, Valid cycle 2+MEM_LAT (cycle 4 at default).
- Outside ISSUE: MemEn=0 and MemWe=0; MemAddr/MemWdata hold their last values.
- IfAbort while a fetch is in ISSUE or WAIT:
  - the fetch is marked cancelled; the memory read still completes.
  - IfRdata is not updated and IfValid stays 0.
  - the state still passes through DONE, so timing is identical.
- IfAbort has no effect on data transactions.
- StallIF = IfReq & ~IfValid & ~IfAbort, combinational.
- StallMEM = DmReq & ~DmValid, combinational.
- Requests dropped before grant are never issued. Requests dropped after grant still complete, and the Valid pulse still occurs.

Test Plan:
1. Lone fetch, MEM_LAT=2: IfReq=1, IfAddr=0x10, memory returns 0x20080005 -> MemEn=1 and MemAddr=0x10 in cycle 1 only; IfValid=1 in cycle 4 with IfRdata=0x20080005; StallIF=1 in cycles 0-3, 0 in cycle 4.
2. Simultaneous load and fetch in cycle 0: DmAddr=0x40 returns 7, IfAddr=0x14 -> DM MemEn cycle 1, DmValid cycle 4 with DmRdata=7; IF MemEn cycle 5, IfValid cycle 8; StallIF=1 in cycles 0-7.
3. Store: DmWe=1, DmAddr=0x44, DmWdata=0xDEADBEEF -> MemEn=MemWe=1 with those values in cycle 1; DmValid cycle 2; DmRdata unchanged.
4. Both requesters re-raise requests continuously for 40 cycles -> grants alternate DM, IF, DM, IF, ...; each Valid pulse is exactly one cycle, and there is never more than one MemEn per transaction.
5. IfAbort=1 in cycle 2 of a fetch while DmReq is pending -> IfValid never asserts; IfRdata unchanged; DM MemEn in cycle 5.
6. Rst_n=0 in cycle 3 of a load -> in cycle 4 all outputs are 0 and Busy=0; no DmValid ever pulses; a new DmReq afterwards completes normally with 4-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF fetch and MEM data requests; DM wins ties, Valid-holder yields.
// Latency: store Valid at req+2, load/fetch Valid at req+2+MEM_LAT; Stall outputs back-pressure the pipeline.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              IfReq,
   input  logic [ADDR_W-1:0] IfAddr,
   input  logic              IfAbort,
   output logic [DATA_W-1:0] IfRdata,
   output logic              IfValid,
   input  logic              DmReq,
   input  logic              DmWe,
   input  logic [ADDR_W-1:0] DmAddr,
   input  logic [DATA_W-1:0] DmWdata,
   output logic [DATA_W-1:0] DmRdata,
   output logic              DmValid,
   output logic              MemEn,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   output logic              StallIF,
   output logic              StallMEM,
   output logic              Busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              dm_q, dm_d;
   logic              we_q, we_d;
   logic              cancel_q, cancel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              avail, grant_dm, grant_if;

   assign IfValid  = (state_q == S_DONE) && !dm_q && !cancel_q;
   assign DmValid  = (state_q == S_DONE) && dm_q;
   assign MemEn    = (state_q == S_ISSUE);
   assign MemWe    = MemEn && we_q;
   assign MemAddr  = addr_q;
   assign MemWdata = wdata_q;
   assign IfRdata  = if_rdata_q;
   assign DmRdata  = dm_rdata_q;
   assign Busy     = (state_q != S_IDLE);
   assign StallIF  = IfReq && !IfValid && !IfAbort;
   assign StallMEM = DmReq && !DmValid;

   // The requester completing this cycle is skipped, so continuous requests alternate.
   assign avail    = (state_q == S_IDLE) || (state_q == S_DONE);
   assign grant_dm = avail && DmReq && !DmValid;
   assign grant_if = avail && !grant_dm && IfReq && !IfAbort && !IfValid;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dm_d       = dm_q;
      we_d       = we_q;
      cancel_d   = cancel_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (grant_dm) begin
               state_d  = S_ISSUE;
               dm_d     = 1'b1;
               we_d     = DmWe;
               addr_d   = DmAddr;
               wdata_d  = DmWdata;
               cancel_d = 1'b0;
            end else if (grant_if) begin
               state_d  = S_ISSUE;
               dm_d     = 1'b0;
               we_d     = 1'b0;
               addr_d   = IfAddr;
               cancel_d = 1'b0;
            end
         end
         S_ISSUE: begin
            if (!dm_q && IfAbort) cancel_d = 1'b1;
            if (we_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 4'(MEM_LAT - 1);
            end
         end
         S_WAIT: begin
            // A flushed fetch still runs to DONE so port timing is unchanged.
            if (!dm_q && IfAbort) cancel_d = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               if (dm_q)           dm_rdata_d = MemRdata;
               else if (!cancel_d) if_rdata_d = MemRdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dm_q       <= 1'b0;
         we_q       <= 1'b0;
         cancel_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dm_q       <= dm_d;
         we_q       <= we_d;
         cancel_q   <= cancel_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model.
// Cycle c starts 1 time unit after a posedge; outputs are sampled on the following negedge.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        Clk, Rst_n;
   logic        IfReq, IfAbort, DmReq, DmWe, IfValid, DmValid;
   logic [31:0] IfAddr, DmAddr, DmWdata, IfRdata, DmRdata;
   logic        MemEn, MemWe, StallIF, StallMEM, Busy;
   logic [31:0] MemAddr, MemWdata, MemRdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .IfReq(IfReq), .IfAddr(IfAddr), .IfAbort(IfAbort), .IfRdata(IfRdata), .IfValid(IfValid),
      .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWdata(DmWdata),
      .DmRdata(DmRdata), .DmValid(DmValid),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemRdata(MemRdata),
      .StallIF(StallIF), .StallMEM(StallMEM), .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] rdfun(input logic [31:0] a);
      case (a)
         32'h10:  return 32'h2008_0005;
         32'h14:  return 32'h8C09_0040;
         32'h40:  return 32'h0000_0007;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Read data only becomes valid LAT cycles after the MemEn cycle.
   logic [31:0] rd_addr = '0;
   int          lat_cnt = 0;
   always @(posedge Clk) begin
      if (MemEn) begin
         rd_addr <= MemAddr;
         lat_cnt <= 1;
      end else if (lat_cnt < 15) begin
         lat_cnt <= lat_cnt + 1;
      end
   end
   assign MemRdata = (lat_cnt >= LAT) ? rdfun(rd_addr) : 32'hBAD0_BAD0;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   logic        men[64], mwe[64], iv[64], dv[64], sif[64], smem[64], bsy[64];
   logic [31:0] maddr[64], mwd[64], ird[64], drd[64];

   // Runs n cycles, recording outputs; requesters drop after their Valid unless hold is set.
   task automatic run(input int n, input bit hold, input int abort_c, input int rst_c, input int dmreq_c);
      for (int c = 0; c < n; c++) begin
         IfAbort = (c == abort_c);
         if (c == abort_c) IfReq = 1'b0;
         Rst_n = (c != rst_c);
         if (c == rst_c) DmReq = 1'b0;
         if (c == dmreq_c) DmReq = 1'b1;
         @(negedge Clk);
         men[c] = MemEn;   mwe[c] = MemWe;     iv[c]  = IfValid;  dv[c]  = DmValid;
         sif[c] = StallIF; smem[c] = StallMEM; bsy[c] = Busy;
         maddr[c] = MemAddr; mwd[c] = MemWdata; ird[c] = IfRdata; drd[c] = DmRdata;
         @(posedge Clk); #1;
         if (!hold) begin
            if (iv[c]) IfReq = 1'b0;
            if (dv[c]) DmReq = 1'b0;
         end
      end
      IfAbort = 1'b0;
      Rst_n   = 1'b1;
   endtask

   initial begin
      int  ne, nv;
      bit  exp_dm;
      Rst_n = 1'b0; IfReq = 1'b0; IfAbort = 1'b0; DmReq = 1'b0; DmWe = 1'b0;
      IfAddr = '0; DmAddr = '0; DmWdata = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst MemEn", MemEn, 0);     chk("rst MemWe", MemWe, 0);
      chk("rst MemAddr", MemAddr, 0); chk("rst Busy", Busy, 0);
      chk("rst IfValid", IfValid, 0); chk("rst DmValid", DmValid, 0);
      chk("rst IfRdata", IfRdata, 0); chk("rst DmRdata", DmRdata, 0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;

      // Lone fetch
      IfAddr = 32'h10; IfReq = 1'b1;
      run(6, 0, -1, -1, -1);
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("t1 MemEn c%0d", c), men[c], c == 1);
         chk($sformatf("t1 IfValid c%0d", c), iv[c], c == 4);
         chk($sformatf("t1 StallIF c%0d", c), sif[c], c < 4);
      end
      chk("t1 MemAddr", maddr[1], 32'h10);
      chk("t1 IfRdata", ird[4], 32'h2008_0005);
      chk("t1 Busy idle", bsy[5], 0);

      // Simultaneous load and fetch
      DmAddr = 32'h40; DmWe = 1'b0; DmReq = 1'b1; IfAddr = 32'h14; IfReq = 1'b1;
      run(10, 0, -1, -1, -1);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("t2 MemEn c%0d", c), men[c], (c == 1) || (c == 5));
         chk($sformatf("t2 DmValid c%0d", c), dv[c], c == 4);
         chk($sformatf("t2 IfValid c%0d", c), iv[c], c == 8);
         chk($sformatf("t2 StallIF c%0d", c), sif[c], c < 8);
         chk($sformatf("t2 StallMEM c%0d", c), smem[c], c < 4);
      end
      chk("t2 DM MemAddr", maddr[1], 32'h40);
      chk("t2 IF MemAddr", maddr[5], 32'h14);
      chk("t2 DmRdata", drd[4], 32'h7);
      chk("t2 IfRdata", ird[8], 32'h8C09_0040);

      // Store
      DmWe = 1'b1; DmAddr = 32'h44; DmWdata = 32'hDEAD_BEEF; DmReq = 1'b1;
      run(4, 0, -1, -1, -1);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("t3 MemEn c%0d", c), men[c], c == 1);
         chk($sformatf("t3 MemWe c%0d", c), mwe[c], c == 1);
         chk($sformatf("t3 DmValid c%0d", c), dv[c], c == 2);
      end
      chk("t3 MemAddr", maddr[1], 32'h44);
      chk("t3 MemWdata", mwd[1], 32'hDEAD_BEEF);
      chk("t3 DmRdata kept", drd[3], 32'h7);
      DmWe = 1'b0;

      // Continuous requests from both sides
      IfAddr = 32'h18; DmAddr = 32'h48; IfReq = 1'b1; DmReq = 1'b1;
      run(40, 1, -1, -1, -1);
      ne = 0; nv = 0; exp_dm = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (men[c]) ne++;
         if (iv[c] || dv[c]) begin
            nv++;
            chk($sformatf("t4 order c%0d", c), dv[c], exp_dm);
            chk($sformatf("t4 both valid c%0d", c), iv[c] & dv[c], 0);
            if (c < 39) chk($sformatf("t4 pulse width c%0d", c), iv[c+1] | dv[c+1], 0);
            exp_dm = !exp_dm;
         end
      end
      chk("t4 MemEn count", ne, 10);
      chk("t4 Valid count", nv, 9);
      IfReq = 1'b0; DmReq = 1'b0;
      run(4, 0, -1, -1, -1);
      chk("t4 late IfValid", iv[0], 1);
      chk("t4 late IfRdata", ird[0], rdfun(32'h18));
      chk("t4 drain MemEn", men[1] | men[2] | men[3], 0);
      chk("t4 drain Busy", bsy[3], 0);

      // Fetch flushed in its cycle 2 while a load waits
      IfAddr = 32'h1C; IfReq = 1'b1; DmAddr = 32'h40;
      run(10, 0, 2, -1, 1);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("t5 IfValid c%0d", c), iv[c], 0);
         chk($sformatf("t5 IfRdata c%0d", c), ird[c], rdfun(32'h18));
         chk($sformatf("t5 MemEn c%0d", c), men[c], (c == 1) || (c == 5));
      end
      chk("t5 StallIF c0", sif[0], 1);
      chk("t5 StallIF abort", sif[2], 0);
      chk("t5 DM MemAddr", maddr[5], 32'h40);
      chk("t5 DmValid", dv[8], 1);

      // Reset in the middle of a load
      DmAddr = 32'h4C; DmReq = 1'b1;
      run(6, 0, -1, 3, -1);
      for (int c = 0; c < 6; c++) chk($sformatf("t6 no DmValid c%0d", c), dv[c], 0);
      chk("t6 MemEn", men[4], 0);      chk("t6 MemWe", mwe[4], 0);
      chk("t6 MemAddr", maddr[4], 0);  chk("t6 MemWdata", mwd[4], 0);
      chk("t6 IfRdata", ird[4], 0);    chk("t6 DmRdata", drd[4], 0);
      chk("t6 IfValid", iv[4], 0);     chk("t6 Busy", bsy[4], 0);
      DmAddr = 32'h40; DmReq = 1'b1;
      run(6, 0, -1, -1, -1);
      for (int c = 0; c < 6; c++) chk($sformatf("t6 DmValid again c%0d", c), dv[c], c == 4);
      chk("t6 MemEn again", men[1], 1);
      chk("t6 DmRdata again", drd[4], 32'h7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
